// File: rtl/i2c_master_arbiter.sv
// Round-robin front end that shares one I2C master between NUM_REQ clients.
// The winner's single-byte transaction is latched and issued over a valid/ready
// command port. The arbiter then waits, with a bounded timer, for the master's
// response strobe and returns the result to the winner with a one-cycle done pulse.
//
// Handshake: a command transfers on any posedge where m_cmd_valid_o and
// m_cmd_ready_i are both high. While valid is high and ready is low, valid,
// rw, addr and wdata are held stable. Valid drops in the cycle after the
// transfer. m_rsp_valid_i is a one-cycle strobe and is only looked at in WAIT.
module i2c_master_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int TIMEOUT_W = 10,
   localparam int PW       = $clog2(NUM_REQ)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NUM_REQ-1:0]   req_i,
   input  logic [NUM_REQ-1:0]   req_rw_i,
   input  logic [7*NUM_REQ-1:0] req_addr_i,
   input  logic [8*NUM_REQ-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]   gnt_o,
   output logic [NUM_REQ-1:0]   done_o,
   output logic [7:0]           rdata_o,
   output logic                 nack_o,
   output logic                 timeout_o,
   output logic                 busy_o,
   output logic                 m_cmd_valid_o,
   input  logic                 m_cmd_ready_i,
   output logic                 m_cmd_rw_o,
   output logic [6:0]           m_cmd_addr_o,
   output logic [7:0]           m_cmd_wdata_o,
   input  logic                 m_rsp_valid_i,
   input  logic [7:0]           m_rsp_rdata_i,
   input  logic                 m_rsp_nack_i,
   output logic [1:0]           dbg_state_o,
   output logic [PW-1:0]        dbg_ptr_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   // The timer holds (WAIT cycles seen - 1). When it sits at max-1, the
   // current WAIT cycle is number 2^TIMEOUT_W-1, which is the last one allowed.
   localparam logic [TIMEOUT_W-1:0] T_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

   state_e                 state_q;
   logic [PW-1:0]          ptr_q;
   logic [TIMEOUT_W-1:0]   timer_q;
   logic [NUM_REQ-1:0]     gnt_q;
   logic [NUM_REQ-1:0]     done_q;
   logic [7:0]             rdata_q;
   logic                   nack_q;
   logic                   timeout_q;
   logic                   cmd_valid_q;
   logic                   rw_q;
   logic [6:0]             addr_q;
   logic [7:0]             wdata_q;

   logic                   found;
   logic [PW-1:0]          win;
   logic [PW-1:0]          ptr_d;
   int                     idx;

   // Round-robin pick: first asserted request scanning ptr, ptr+1, ... wrapping.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_i[idx]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
   end

   assign ptr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;

   // Transaction FSM with all outputs registered.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         timer_q     <= '0;
         gnt_q       <= '0;
         done_q      <= '0;
         rdata_q     <= '0;
         nack_q      <= 1'b0;
         timeout_q   <= 1'b0;
         cmd_valid_q <= 1'b0;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (found) begin
                  gnt_q       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                  rw_q        <= req_rw_i[win];
                  addr_q      <= req_addr_i[7*win +: 7];
                  wdata_q     <= req_wdata_i[8*win +: 8];
                  ptr_q       <= ptr_d;
                  cmd_valid_q <= 1'b1;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (cmd_valid_q && m_cmd_ready_i) begin
                  cmd_valid_q <= 1'b0;
                  timer_q     <= '0;
                  state_q     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (m_rsp_valid_i) begin
                  nack_q    <= m_rsp_nack_i;
                  timeout_q <= 1'b0;
                  rdata_q   <= (!rw_q && !m_rsp_nack_i) ? m_rsp_rdata_i : 8'h00;
                  done_q    <= gnt_q;
                  state_q   <= S_DONE;
               end else if (timer_q == T_LAST) begin
                  nack_q    <= 1'b1;
                  timeout_q <= 1'b1;
                  rdata_q   <= 8'h00;
                  done_q    <= gnt_q;
                  state_q   <= S_DONE;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            S_DONE: begin
               done_q  <= '0;
               gnt_q   <= '0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign gnt_o         = gnt_q;
   assign done_o        = done_q;
   assign rdata_o       = rdata_q;
   assign nack_o        = nack_q;
   assign timeout_o     = timeout_q;
   assign busy_o        = (state_q != S_IDLE);
   assign m_cmd_valid_o = cmd_valid_q;
   assign m_cmd_rw_o    = rw_q;
   assign m_cmd_addr_o  = addr_q;
   assign m_cmd_wdata_o = wdata_q;
   assign dbg_state_o   = state_q;
   assign dbg_ptr_o     = ptr_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter: arbitration order, handshake,
// response capture, timeout boundary and asynchronous reset.
module tb_i2c_master_arbiter;

   localparam int NR = 4;
   localparam int TW = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk = ~clk;

   logic [NR-1:0]   req;
   logic [NR-1:0]   req_rw;
   logic [7*NR-1:0] req_addr;
   logic [8*NR-1:0] req_wdata;
   logic [NR-1:0]   gnt;
   logic [NR-1:0]   done;
   logic [7:0]      rdata;
   logic            nack;
   logic            tmo;
   logic            busy;
   logic            m_cmd_valid;
   logic            m_cmd_ready;
   logic            m_cmd_rw;
   logic [6:0]      m_cmd_addr;
   logic [7:0]      m_cmd_wdata;
   logic            m_rsp_valid;
   logic [7:0]      m_rsp_rdata;
   logic            m_rsp_nack;
   logic [1:0]      dbg_state;
   logic [1:0]      dbg_ptr;

   i2c_master_arbiter #(.NUM_REQ(NR), .TIMEOUT_W(TW)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .req_i        (req),
      .req_rw_i     (req_rw),
      .req_addr_i   (req_addr),
      .req_wdata_i  (req_wdata),
      .gnt_o        (gnt),
      .done_o       (done),
      .rdata_o      (rdata),
      .nack_o       (nack),
      .timeout_o    (tmo),
      .busy_o       (busy),
      .m_cmd_valid_o(m_cmd_valid),
      .m_cmd_ready_i(m_cmd_ready),
      .m_cmd_rw_o   (m_cmd_rw),
      .m_cmd_addr_o (m_cmd_addr),
      .m_cmd_wdata_o(m_cmd_wdata),
      .m_rsp_valid_i(m_rsp_valid),
      .m_rsp_rdata_i(m_rsp_rdata),
      .m_rsp_nack_i (m_rsp_nack),
      .dbg_state_o  (dbg_state),
      .dbg_ptr_o    (dbg_ptr)
   );

   // ---------------- scoreboard ----------------
   int n_total = 0;
   int n_bad   = 0;
   logic [1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic set_slot(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d);
      req_rw[i]          = rw;
      req_addr[7*i +: 7] = a;
      req_wdata[8*i +: 8] = d;
   endtask

   task automatic wait_gnt(input logic level);
      int n;
      n = 0;
      while (((|gnt) != level) && n < 20) begin
         tick();
         n++;
      end
      check("wait_gnt", 32'(|gnt), 32'(level));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      logic [1:0] e;
      req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
      m_cmd_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_rdata = '0; m_rsp_nack = 1'b0;
      do_reset();

      // reset state
      check("rst_gnt", gnt, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", m_cmd_valid, 0);
      check("rst_state", dbg_state, 0);
      check("rst_ptr", dbg_ptr, 0);

      // 1: single read, ready held high
      set_slot(0, 1'b0, 7'h50, 8'h00);
      m_cmd_ready = 1'b1;
      req = 4'b0001;
      tick();                                   // cycle 1
      check("t1_gnt", gnt, 4'b0001);
      check("t1_valid", m_cmd_valid, 1);
      check("t1_addr", m_cmd_addr, 7'h50);
      check("t1_rw", m_cmd_rw, 0);
      req = 4'b0000;
      tick();                                   // cycle 2
      check("t1_wait", dbg_state, 2);
      check("t1_valid_low", m_cmd_valid, 0);
      m_rsp_valid = 1'b1; m_rsp_rdata = 8'hA5; m_rsp_nack = 1'b0;
      tick();                                   // cycle 3
      m_rsp_valid = 1'b0;
      check("t1_done", done, 4'b0001);
      check("t1_gnt_done", gnt, 4'b0001);
      check("t1_rdata", rdata, 8'hA5);
      check("t1_nack", nack, 0);
      check("t1_tmo", tmo, 0);
      tick();                                   // cycle 4
      check("t1_done_clr", done, 0);
      check("t1_gnt_clr", gnt, 0);
      check("t1_idle", busy, 0);
      check("t1_rdata_hold", rdata, 8'hA5);

      // 2: round robin, all requesting, immediate ready/response
      do_reset();
      for (int i = 0; i < NR; i++) set_slot(i, 1'b0, 7'(8'h10 + i), 8'h00);
      exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
      exp_q.push_back(2'd3); exp_q.push_back(2'd0);
      m_rsp_valid = 1'b1; m_rsp_rdata = 8'h5A; m_rsp_nack = 1'b0;
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         wait_gnt(1'b1);
         e = exp_q.pop_front();
         check("rr_gnt", gnt, 4'b0001 << e);
         if (g == 3) check("rr_ptr_wrap", dbg_ptr, 0);
         if (g == 4) req = 4'b0000;
         wait_gnt(1'b0);
      end
      m_rsp_valid = 1'b0;
      check("rr_idle", busy, 0);
      check("rr_ptr_end", dbg_ptr, 1);

      // 3: backpressure on requester 1, response strobes in ISSUE ignored
      set_slot(1, 1'b0, 7'h2A, 8'h96);
      m_cmd_ready = 1'b0;
      req = 4'b0010;
      tick();
      check("bp_gnt", gnt, 4'b0010);
      req = 4'b0000;
      set_slot(1, 1'b1, 7'h11, 8'h00);
      m_rsp_valid = 1'b1; m_rsp_rdata = 8'hEE;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", m_cmd_valid, 1);
         check("bp_addr", m_cmd_addr, 7'h2A);
         check("bp_wdata", m_cmd_wdata, 8'h96);
         check("bp_rw", m_cmd_rw, 0);
         check("bp_no_done", done, 0);
         tick();
      end
      m_rsp_valid = 1'b0;
      m_cmd_ready = 1'b1;
      tick();
      check("bp_accepted", dbg_state, 2);
      check("bp_valid_low", m_cmd_valid, 0);
      m_rsp_valid = 1'b1; m_rsp_rdata = 8'h77; m_rsp_nack = 1'b0;
      tick();
      m_rsp_valid = 1'b0;
      check("bp_done", done, 4'b0010);
      check("bp_rdata", rdata, 8'h77);
      tick();

      // 4a: timeout, no response (15 WAIT cycles with TIMEOUT_W=4)
      set_slot(2, 1'b0, 7'h33, 8'h00);
      req = 4'b0100;
      tick();
      check("to_gnt", gnt, 4'b0100);
      req = 4'b0000;
      tick();                                   // first WAIT cycle
      n = 0;
      while (done == 0 && n < 40) begin
         tick();
         n++;
      end
      check("to_wait_cycles", n, 15);
      check("to_done", done, 4'b0100);
      check("to_nack", nack, 1);
      check("to_tmo", tmo, 1);
      check("to_rdata", rdata, 0);
      tick();

      // 4b: response arrives in the 15th WAIT cycle -> response wins
      set_slot(3, 1'b0, 7'h21, 8'h00);
      req = 4'b1000;
      tick();
      check("tb_gnt", gnt, 4'b1000);
      req = 4'b0000;
      tick();                                   // WAIT cycle 1
      repeat (14) tick();                       // WAIT cycle 15
      check("tb_no_done_yet", done, 0);
      m_rsp_valid = 1'b1; m_rsp_rdata = 8'hC3; m_rsp_nack = 1'b0;
      tick();
      m_rsp_valid = 1'b0;
      check("tb_done", done, 4'b1000);
      check("tb_tmo", tmo, 0);
      check("tb_nack", nack, 0);
      check("tb_rdata", rdata, 8'hC3);
      tick();

      // 5: write answered with NACK
      set_slot(0, 1'b1, 7'h44, 8'h3C);
      req = 4'b0001;
      tick();
      check("wn_gnt", gnt, 4'b0001);
      check("wn_wdata", m_cmd_wdata, 8'h3C);
      check("wn_rw", m_cmd_rw, 1);
      check("wn_addr", m_cmd_addr, 7'h44);
      req = 4'b0000;
      tick();
      m_rsp_valid = 1'b1; m_rsp_rdata = 8'hFF; m_rsp_nack = 1'b1;
      tick();
      m_rsp_valid = 1'b0; m_rsp_nack = 1'b0;
      check("wn_done", done, 4'b0001);
      check("wn_nack", nack, 1);
      check("wn_rdata", rdata, 0);
      check("wn_tmo", tmo, 0);
      tick();

      // 6: asynchronous reset in WAIT
      set_slot(1, 1'b0, 7'h55, 8'h00);
      req = 4'b0010;
      tick();
      req = 4'b0000;
      tick();
      check("rw_in_wait", dbg_state, 2);
      rst_ni = 1'b0;
      #2;
      check("rw_gnt", gnt, 0);
      check("rw_busy", busy, 0);
      check("rw_valid", m_cmd_valid, 0);
      check("rw_done", done, 0);
      check("rw_ptr", dbg_ptr, 0);
      check("rw_addr", m_cmd_addr, 0);
      @(negedge clk);
      rst_ni = 1'b1;
      tick();
      tick();
      check("rw_no_done", done, 0);
      set_slot(2, 1'b0, 7'h66, 8'h00);
      req = 4'b0100;
      tick();
      check("rw_gnt2", gnt, 4'b0100);
      check("rw_ptr_next", dbg_ptr, 3);
      req = 4'b0000;
      tick();
      m_rsp_valid = 1'b1; m_rsp_rdata = 8'h12;
      tick();
      m_rsp_valid = 1'b0;
      check("rw_done2", done, 4'b0100);
      check("rw_rdata2", rdata, 8'h12);
      tick();

      // ---------------- report ----------------
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
